fetch_ctrl: RTL and testbench

- Sequencer for the instruction-fetch path. Owns the PC and drives a request/acknowledge instruction memory that may take a variable number of cycles.
- Buffers fetched instructions in a 2-entry queue so decode can stall without losing data.
- Applies branch/jump redirects from execute, including redirects that arrive while a memory request is still outstanding.
- Sits between the instruction memory and the decode stage.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_ctrl_if.sv | 12 +
 rtl/fetch_queue.sv | 72 +++++++
 rtl/fetch_ctrl.sv | 110 +++++++++++
 tb/tb_fetch_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [0:0] {
    StFetch,
    StDrain
  } fetch_state_e;

  localparam logic [31:0]  DefaultResetPc = 32'h0000_0000;
  localparam int unsigned  FetchQDepth    = 2;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Request/acknowledge instruction-memory bus between fetch and imem.
interface fetch_ctrl_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 req;
  logic [DataWidth-1:0] addr;
  logic                 ack;
  logic [DataWidth-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of {instr, pc}; the head sits in entry 0 so outputs come straight from flops.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] push_instr_i,
  input  logic [DataWidth-1:0] push_pc_i,
  input  logic                 pop_i,
  input  logic                 clear_i,
  output logic [1:0]           count_o,
  output logic                 head_valid_o,
  output logic [DataWidth-1:0] head_instr_o,
  output logic [DataWidth-1:0] head_pc_o
);

  localparam logic [1:0] QFull = 2'(FetchQDepth);

  logic [DataWidth-1:0] instr_q [FetchQDepth];
  logic [DataWidth-1:0] instr_d [FetchQDepth];
  logic [DataWidth-1:0] pc_q    [FetchQDepth];
  logic [DataWidth-1:0] pc_d    [FetchQDepth];
  logic [1:0]           count_q, count_d;
  logic [1:0]           wr_idx;
  logic                 pop, push;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    count_d = count_q;
    pop     = pop_i && (count_q != 2'd0);
    push    = push_i && ((count_q < QFull) || pop);
    wr_idx  = count_q - 2'(pop);
    if (clear_i) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        instr_d[0] = instr_q[1];
        pc_d[0]    = pc_q[1];
      end
      // Push after the shift so a push into the vacated slot wins.
      if (push) begin
        instr_d[wr_idx[0]] = push_instr_i;
        pc_d[wr_idx[0]]    = push_pc_i;
      end
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= 2'd0;
      for (int i = 0; i < FetchQDepth; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      count_q <= count_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign count_o      = count_q;
  assign head_valid_o = (count_q != 2'd0);
  assign head_instr_o = instr_q[0];
  assign head_pc_o    = pc_q[0];

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues imem requests, drains abandoned requests after redirects.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = DATA_WIDTH'(DefaultResetPc)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  input  logic                  stall,
  fetch_ctrl_if.master          imem,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic [DATA_WIDTH-1:0] instr_pcplus4
);

  localparam logic [1:0] QFull = 2'(FetchQDepth);

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] drain_addr_q, drain_addr_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            q_count;
  logic                  req, ack_eff, push, pop;
  logic [DATA_WIDTH-1:0] target;

  always_comb begin
    req = 1'b0;
    unique case (state_q)
      StFetch: req = inflight_q || (q_count < QFull);
      StDrain: req = 1'b1;
    endcase
    if (!rst) req = 1'b0;
  end

  assign imem.req  = req;
  assign imem.addr = (state_q == StDrain) ? drain_addr_q : pc_q;
  assign ack_eff   = req && imem.ack;
  assign target    = redirect_target & ~DATA_WIDTH'(3);
  assign pop       = instr_valid && !stall;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    inflight_d   = inflight_q;
    push         = 1'b0;
    if (redirect_valid) begin
      pc_d       = target;
      inflight_d = 1'b0;
      if (state_q == StFetch && req && !ack_eff) begin
        state_d      = StDrain;
        drain_addr_d = pc_q;
      end else if (state_q == StDrain && ack_eff) begin
        state_d = StFetch;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (ack_eff) begin
            push       = 1'b1;
            pc_d       = pc_q + DATA_WIDTH'(4);
            inflight_d = 1'b0;
          end else begin
            inflight_d = req;
          end
        end
        StDrain: begin
          if (ack_eff) state_d = StFetch;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      inflight_q   <= inflight_d;
    end
  end

  fetch_queue #(
    .DataWidth (DATA_WIDTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_instr_i (imem.rdata),
    .push_pc_i    (pc_q),
    .pop_i        (pop),
    .clear_i      (redirect_valid),
    .count_o      (q_count),
    .head_valid_o (instr_valid),
    .head_instr_o (Instr),
    .head_pc_o    (instr_pc)
  );

  assign instr_pcplus4 = instr_pc + DATA_WIDTH'(4);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed table-driven bench for fetch_ctrl; memory returns ~addr as the instruction word.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        ack_drv;

  logic        instr_valid, instr_valid2;
  logic [31:0] instr, instr_pc, instr_pcplus4;
  logic [31:0] instr2, instr_pc2, instr_pcplus4_2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_ctrl_if #(.DataWidth(32)) mif ();
  fetch_ctrl_if #(.DataWidth(32)) mif2 ();

  assign mif.ack    = ack_drv;
  assign mif.rdata  = ~mif.addr;
  assign mif2.ack   = 1'b1;
  assign mif2.rdata = ~mif2.addr;

  fetch_ctrl #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .stall           (stall),
    .imem            (mif.master),
    .instr_valid     (instr_valid),
    .Instr           (instr),
    .instr_pc        (instr_pc),
    .instr_pcplus4   (instr_pcplus4)
  );

  fetch_ctrl #(
    .DATA_WIDTH (32),
    .RESET_PC   (32'hFFFF_FFF8)
  ) dut2 (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (1'b0),
    .redirect_target (32'h0),
    .stall           (1'b0),
    .imem            (mif2.master),
    .instr_valid     (instr_valid2),
    .Instr           (instr2),
    .instr_pc        (instr_pc2),
    .instr_pcplus4   (instr_pcplus4_2)
  );

  typedef struct {
    bit          rst_before;
    bit          stall;
    bit          rv;
    logic [31:0] tgt;
    bit          ack;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit s, bit rv, logic [31:0] tgt, bit ack,
                              bit e_req, logic [31:0] e_addr, bit e_valid, logic [31:0] e_pc);
    vec_t v;
    v.rst_before = r;
    v.stall = s;
    v.rv = rv;
    v.tgt = tgt;
    v.ack = ack;
    v.e_req = e_req;
    v.e_addr = e_addr;
    v.e_valid = e_valid;
    v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called right after a posedge; returns right after the second reset edge.
  task automatic do_reset();
    #1;
    rst = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    ack_drv = 1'b0;
    @(negedge clk);
    check("req_forced_low_in_reset", 32'(mif.req), 32'h0);
    check("req2_forced_low_in_reset", 32'(mif2.req), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(instr_valid), 32'h0);
    check("reset_instr", instr, 32'h0);
    check("reset_pc", instr_pc, 32'h0);
    check("reset_pcplus4", instr_pcplus4, 32'h4);
    @(posedge clk);
  endtask

  task automatic apply(int idx, vec_t v);
    if (v.rst_before) do_reset();
    #1;
    rst = 1'b1;
    stall = v.stall;
    redirect_valid = v.rv;
    redirect_target = v.tgt;
    ack_drv = v.ack;
    @(negedge clk);
    check($sformatf("v%0d_req", idx), 32'(mif.req), 32'(v.e_req));
    if (v.e_req) check($sformatf("v%0d_addr", idx), mif.addr, v.e_addr);
    check($sformatf("v%0d_valid", idx), 32'(instr_valid), 32'(v.e_valid));
    if (v.e_valid) begin
      check($sformatf("v%0d_pc", idx), instr_pc, v.e_pc);
      check($sformatf("v%0d_instr", idx), instr, ~v.e_pc);
      check($sformatf("v%0d_pcplus4", idx), instr_pcplus4, v.e_pc + 32'd4);
    end
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    ack_drv = 1'b0;

    // Zero-wait memory, no stall
    vecs.push_back(mk(1, 0, 0, 0, 1,  1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 32'h4, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 32'h8, 1, 32'h4));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 32'hC, 1, 32'h8));
    // Stall fills the queue, release keeps order
    vecs.push_back(mk(1, 1, 0, 0, 1,  1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1,  1, 32'h4, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 1,  0, 32'h0, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 1,  0, 32'h0, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 1,  0, 32'h0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  0, 32'h0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 32'h8, 1, 32'h4));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 32'hC, 1, 32'h8));
    // 3-cycle memory, redirect in 2nd wait cycle of addr 8
    vecs.push_back(mk(1, 0, 0, 0, 0,  1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 32'h4, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 32'h4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 32'h4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 32'h8, 1, 32'h4));
    vecs.push_back(mk(0, 0, 1, 32'h100, 0, 1, 32'h8, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 32'h8, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 32'h8, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 32'h100, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 32'h100, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 32'h104, 1, 32'h100));
    // Redirect coincident with ack of addr C while the queue would fill
    vecs.push_back(mk(1, 0, 0, 0, 1,  1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 32'h4, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 32'h8, 1, 32'h4));
    vecs.push_back(mk(0, 1, 1, 32'h200, 1, 1, 32'hC, 1, 32'h8));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 32'h200, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 32'h204, 1, 32'h200));
    // Repeated redirects while draining; low target bits ignored
    vecs.push_back(mk(1, 0, 1, 32'h100, 0, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h300, 0, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 32'h403, 0, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1,  1, 32'h400, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 32'h404, 1, 32'h400));
    // Enter drain, then reset below
    vecs.push_back(mk(1, 0, 1, 32'h100, 0, 1, 32'h0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0,  1, 32'h0, 0, 0));

    @(posedge clk);
    foreach (vecs[i]) apply(i, vecs[i]);

    // Reset while draining abandons the request; both instances restart at RESET_PC
    do_reset();
    #1;
    rst = 1'b1;
    ack_drv = 1'b1;
    @(negedge clk);
    check("post_drain_reset_req", 32'(mif.req), 32'h1);
    check("post_drain_reset_addr", mif.addr, 32'h0);
    check("wrap_addr0", mif2.addr, 32'hFFFF_FFF8);
    check("wrap_valid0", 32'(instr_valid2), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("post_drain_reset_pc", instr_pc, 32'h0);
    check("wrap_addr1", mif2.addr, 32'hFFFF_FFFC);
    check("wrap_pc1", instr_pc2, 32'hFFFF_FFF8);
    check("wrap_instr1", instr2, 32'h0000_0007);
    @(posedge clk);
    @(negedge clk);
    check("wrap_addr2", mif2.addr, 32'h0000_0000);
    check("wrap_pc2", instr_pc2, 32'hFFFF_FFFC);
    check("wrap_pcplus4_2", instr_pcplus4_2, 32'h0000_0000);
    @(posedge clk);
    @(negedge clk);
    check("wrap_pc3", instr_pc2, 32'h0000_0000);
    check("wrap_addr3", mif2.addr, 32'h0000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
